// File: rtl/packet_stream_rr_arbiter_if.sv
// Avalon-ST bundle for packet_stream_rr_arbiter.
// Groups the NUM_INPUTS source-side streams (asi_in_*) and the single merged
// sink-side stream (aso_out0_*).
//   slave  : arbiter view (consumes asi_in_*, produces aso_out0_*)
//   master : environment view (produces asi_in_*, consumes aso_out0_*)
interface packet_stream_rr_arbiter_if #(
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned CH_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) ();

   logic [NUM_INPUTS*DATA_WIDTH-1:0] asi_in_data;
   logic [NUM_INPUTS-1:0]            asi_in_valid;
   logic [NUM_INPUTS-1:0]            asi_in_startofpacket;
   logic [NUM_INPUTS-1:0]            asi_in_endofpacket;
   logic [NUM_INPUTS-1:0]            asi_in_ready;

   logic [DATA_WIDTH-1:0]            aso_out0_data;
   logic                             aso_out0_valid;
   logic                             aso_out0_ready;
   logic                             aso_out0_startofpacket;
   logic                             aso_out0_endofpacket;
   logic [CH_WIDTH-1:0]              aso_out0_channel;

   modport slave (
      input  asi_in_data,
      input  asi_in_valid,
      input  asi_in_startofpacket,
      input  asi_in_endofpacket,
      output asi_in_ready,
      output aso_out0_data,
      output aso_out0_valid,
      input  aso_out0_ready,
      output aso_out0_startofpacket,
      output aso_out0_endofpacket,
      output aso_out0_channel
   );

   modport master (
      output asi_in_data,
      output asi_in_valid,
      output asi_in_startofpacket,
      output asi_in_endofpacket,
      input  asi_in_ready,
      input  aso_out0_data,
      input  aso_out0_valid,
      output aso_out0_ready,
      input  aso_out0_startofpacket,
      input  aso_out0_endofpacket,
      input  aso_out0_channel
   );

endinterface

// File: rtl/packet_stream_rr_arbiter.sv
// Round-robin, packet-locked merge of NUM_INPUTS Avalon-ST packet sources onto
// one Avalon-ST sink with a single registered output stage.
// Ports:
//   clock_clk        : clock
//   reset_reset      : synchronous active-high reset
//   st               : stream bundle (slave modport): asi_in_* sources, aso_out0_* sink
//   cfg_enable_mask  : per-source arbitration enable
//   stat_clear       : pulse, clears stat_drop_flag and stat_pkt_count (wins over updates)
//   stat_drop_flag   : sticky, an orphan (non-SOP beat seen while idle) was discarded
//   stat_pkt_count   : packets whose EOP was accepted downstream (wrapping)
//   stat_busy        : high while a packet is being streamed
module packet_stream_rr_arbiter #(
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned CH_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                   clock_clk,
   input  logic                   reset_reset,
   packet_stream_rr_arbiter_if.slave st,
   input  logic [NUM_INPUTS-1:0]  cfg_enable_mask,
   input  logic                   stat_clear,
   output logic                   stat_drop_flag,
   output logic [15:0]            stat_pkt_count,
   output logic                   stat_busy
);

   typedef enum logic {StIdle, StStream} state_e;

   state_e                state_q, state_d;
   logic [CH_WIDTH-1:0]   grant_q, grant_d;
   logic [CH_WIDTH-1:0]   last_grant_q, last_grant_d;

   logic                  out_valid_q, out_valid_d;
   logic                  out_sop_q, out_sop_d;
   logic                  out_eop_q, out_eop_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CH_WIDTH-1:0]   out_ch_q, out_ch_d;

   logic                  drop_q, drop_d;
   logic [15:0]           pkt_cnt_q, pkt_cnt_d;

   logic [NUM_INPUTS-1:0] req;
   logic [NUM_INPUTS-1:0] orphan;
   logic [NUM_INPUTS-1:0] in_ready;
   logic                  pick_found;
   logic [CH_WIDTH-1:0]   pick_idx;

   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_sop;
   logic                  sel_eop;

   logic                  can_load;
   logic                  accept;
   logic                  drop_seen;
   logic                  out_fire;

   // Round-robin pick: first pass looks above last_grant, second pass wraps to 0.
   always_comb begin
      req        = st.asi_in_valid & st.asi_in_startofpacket & cfg_enable_mask;
      orphan     = st.asi_in_valid & ~st.asi_in_startofpacket;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (!pick_found && req[i] && (CH_WIDTH'(i) > last_grant_q)) begin
            pick_found = 1'b1;
            pick_idx   = CH_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (!pick_found && req[i]) begin
            pick_found = 1'b1;
            pick_idx   = CH_WIDTH'(i);
         end
      end
   end

   // Granted source mux.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_sop   = 1'b0;
      sel_eop   = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (grant_q == CH_WIDTH'(i)) begin
            sel_data  = st.asi_in_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_valid = st.asi_in_valid[i];
            sel_sop   = st.asi_in_startofpacket[i];
            sel_eop   = st.asi_in_endofpacket[i];
         end
      end
   end

   always_comb begin
      can_load     = !out_valid_q || st.aso_out0_ready;
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      in_ready     = '0;
      accept       = 1'b0;
      drop_seen    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               // Decision cycle: nothing is accepted, orphans included.
               grant_d      = pick_idx;
               last_grant_d = pick_idx;
               state_d      = StStream;
            end else begin
               in_ready  = orphan;
               drop_seen = |orphan;
            end
         end
         StStream: begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
               if (grant_q == CH_WIDTH'(i)) begin
                  in_ready[i] = can_load;
               end
            end
            accept = can_load && sel_valid;
            if (accept && sel_eop) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      out_valid_d = out_valid_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      if (can_load) begin
         out_valid_d = accept;
         if (accept) begin
            out_sop_d  = sel_sop;
            out_eop_d  = sel_eop;
            out_data_d = sel_data;
            out_ch_d   = grant_q;
         end
      end

      out_fire  = out_valid_q && st.aso_out0_ready;
      pkt_cnt_d = (out_fire && out_eop_q) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
      drop_d    = drop_q | drop_seen;
      if (stat_clear) begin
         pkt_cnt_d = '0;
         drop_d    = 1'b0;
      end
   end

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= CH_WIDTH'(NUM_INPUTS - 1);
         out_valid_q  <= 1'b0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         out_data_q   <= '0;
         out_ch_q     <= '0;
         drop_q       <= 1'b0;
         pkt_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         out_valid_q  <= out_valid_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         out_data_q   <= out_data_d;
         out_ch_q     <= out_ch_d;
         drop_q       <= drop_d;
         pkt_cnt_q    <= pkt_cnt_d;
      end
   end

   assign st.asi_in_ready           = in_ready;
   assign st.aso_out0_data          = out_data_q;
   assign st.aso_out0_valid         = out_valid_q;
   assign st.aso_out0_startofpacket = out_sop_q;
   assign st.aso_out0_endofpacket   = out_eop_q;
   assign st.aso_out0_channel       = out_ch_q;
   assign stat_drop_flag            = drop_q;
   assign stat_pkt_count            = pkt_cnt_q;
   assign stat_busy                 = (state_q == StStream);

endmodule

// File: tb/tb_packet_stream_rr_arbiter.sv
// Bench for packet_stream_rr_arbiter: directed scenarios plus randomized
// traffic checked against a packet-level reference (per-source beat queues,
// packet atomicity on the output, packet/drop counters).
module tb_packet_stream_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int CW = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic          orphan;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  mask;
   logic          stat_clear;
   logic          drop_flag;
   logic [15:0]   pkt_count;
   logic          busy;

   packet_stream_rr_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .CH_WIDTH(CW)) bus ();

   packet_stream_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .CH_WIDTH(CW)) dut (
      .clock_clk       (clk),
      .reset_reset     (rst),
      .st              (bus),
      .cfg_enable_mask (mask),
      .stat_clear      (stat_clear),
      .stat_drop_flag  (drop_flag),
      .stat_pkt_count  (pkt_count),
      .stat_busy       (busy)
   );

   always #5 clk = ~clk;

   beat_t  src_q[N][$];   // beats still to be offered by each source
   beat_t  exp_q[N][$];   // beats accepted from a source, awaiting output
   int     start_log[$];  // channel of every output packet start
   logic [N-1:0] gap;
   bit     rand_mode;
   int     n_checks;
   int     n_errors;
   int     model_cnt;
   bit     model_drop;
   bit     out_in_pkt;
   int     cur_ch;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic push_pkt(input int s, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data   = ($urandom & 32'h00FF_FFFF) | (32'(s) << 28);
         b.sop    = (k == 0);
         b.eop    = (k == len - 1);
         b.orphan = 1'b0;
         src_q[s].push_back(b);
      end
   endtask

   task automatic push_orphan(input int s);
      beat_t b;
      b.data   = $urandom;
      b.sop    = 1'b0;
      b.eop    = 1'b0;
      b.orphan = 1'b1;
      src_q[s].push_back(b);
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0 && !gap[i]) begin
            bus.asi_in_valid[i]            = 1'b1;
            bus.asi_in_data[i*DW +: DW]    = src_q[i][0].data;
            bus.asi_in_startofpacket[i]    = src_q[i][0].sop;
            bus.asi_in_endofpacket[i]      = src_q[i][0].eop;
         end else begin
            bus.asi_in_valid[i]            = 1'b0;
            bus.asi_in_data[i*DW +: DW]    = '0;
            bus.asi_in_startofpacket[i]    = 1'b0;
            bus.asi_in_endofpacket[i]      = 1'b0;
         end
      end
   endtask

   task automatic flush();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      model_cnt  = 0;
      model_drop = 1'b0;
      out_in_pkt = 1'b0;
      gap        = '0;
   endtask

   function automatic int pending();
      int p = 0;
      for (int i = 0; i < N; i++) p += src_q[i].size() + exp_q[i].size();
      return p;
   endfunction

   task automatic monitor();
      int    ch;
      beat_t e;
      ch = int'(bus.aso_out0_channel);
      if (out_in_pkt) check_eq("atomic_ch", 64'(ch), 64'(cur_ch));
      check_eq("beat_expected", 64'(exp_q[ch].size() != 0), 64'd1);
      if (exp_q[ch].size() != 0) begin
         e = exp_q[ch].pop_front();
         check_eq("beat", {bus.aso_out0_data, bus.aso_out0_startofpacket,
                           bus.aso_out0_endofpacket}, {e.data, e.sop, e.eop});
         if (e.eop) model_cnt = (model_cnt + 1) % 65536;
      end
      if (bus.aso_out0_startofpacket) start_log.push_back(ch);
      out_in_pkt = !bus.aso_out0_endofpacket;
      cur_ch     = ch;
   endtask

   // One clock: observe handshakes at the negedge, update stimulus after posedge.
   task automatic cycle();
      beat_t b;
      @(negedge clk);
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (bus.asi_in_valid[i] && bus.asi_in_ready[i]) begin
               b = src_q[i].pop_front();
               if (b.orphan) model_drop = 1'b1;
               else          exp_q[i].push_back(b);
            end
         end
         if (bus.aso_out0_valid && bus.aso_out0_ready) monitor();
         if (stat_clear) begin
            model_cnt  = 0;
            model_drop = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (rand_mode) begin
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
               push_pkt(i, int'($urandom_range(1, 5)));
            gap[i] = ($urandom_range(0, 4) == 0);
         end
         bus.aso_out0_ready = ($urandom_range(0, 3) != 0);
         stat_clear         = ($urandom_range(0, 199) == 0);
      end
      drive();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      stat_clear = 1'b0;
      flush();
      drive();
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic drain(input int limit);
      for (int k = 0; k < limit; k++) begin
         if (pending() == 0 && !bus.aso_out0_valid) break;
         cycle();
      end
      check_eq("drain_pending", 64'(pending() + int'(bus.aso_out0_valid)), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] a, b, c;
      logic [DW+CW+1:0] snap;
      logic [2:0] busy_seq;

      n_checks           = 0;
      n_errors           = 0;
      mask               = '1;
      stat_clear         = 1'b0;
      rand_mode          = 1'b0;
      bus.aso_out0_ready = 1'b1;
      gap                = '0;
      drive();
      do_reset();

      // Reset state
      check_eq("rst_valid", 64'(bus.aso_out0_valid), 64'd0);
      check_eq("rst_sop_eop", 64'({bus.aso_out0_startofpacket, bus.aso_out0_endofpacket}), 64'd0);
      check_eq("rst_data", 64'(bus.aso_out0_data), 64'd0);
      check_eq("rst_channel", 64'(bus.aso_out0_channel), 64'd0);
      check_eq("rst_drop", 64'(drop_flag), 64'd0);
      check_eq("rst_count", 64'(pkt_count), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);

      // Single source, 3 beats, two-cycle first-beat latency
      push_pkt(0, 3);
      a = src_q[0][0].data;
      b = src_q[0][1].data;
      c = src_q[0][2].data;
      drive();
      #1;
      check_eq("arb_cycle_ready", 64'(bus.asi_in_ready), 64'd0);
      cycle();
      check_eq("t1_busy", 64'(busy), 64'd1);
      check_eq("t1_not_yet", 64'(bus.aso_out0_valid), 64'd0);
      #1;
      check_eq("t1_in_ready", 64'(bus.asi_in_ready), 64'b0001);
      cycle();
      check_eq("t1_beat_a", {bus.aso_out0_valid, bus.aso_out0_data, bus.aso_out0_startofpacket,
                             bus.aso_out0_endofpacket, bus.aso_out0_channel},
               {1'b1, a, 1'b1, 1'b0, 2'd0});
      cycle();
      check_eq("t1_beat_b", {bus.aso_out0_valid, bus.aso_out0_data, bus.aso_out0_startofpacket,
                             bus.aso_out0_endofpacket, bus.aso_out0_channel},
               {1'b1, b, 1'b0, 1'b0, 2'd0});
      cycle();
      check_eq("t1_beat_c", {bus.aso_out0_valid, bus.aso_out0_data, bus.aso_out0_startofpacket,
                             bus.aso_out0_endofpacket, bus.aso_out0_channel},
               {1'b1, c, 1'b0, 1'b1, 2'd0});
      cycle();
      check_eq("t1_count", 64'(pkt_count), 64'd1);
      check_eq("t1_drained", 64'(bus.aso_out0_valid), 64'd0);

      // Round robin with all four sources holding two packets each
      do_reset();
      start_log.delete();
      for (int s = 0; s < N; s++) begin
         push_pkt(s, 2);
         push_pkt(s, 2);
      end
      drive();
      drain(200);
      check_eq("rr_pkts", 64'(start_log.size()), 64'd8);
      for (int k = 0; k < 8 && k < start_log.size(); k++)
         check_eq($sformatf("rr_order%0d", k), 64'(start_log[k]), 64'(k % N));
      check_eq("rr_count", 64'(pkt_count), 64'd8);

      // Backpressure mid-packet
      push_pkt(1, 6);
      drive();
      for (int k = 0; k < 10 && !bus.aso_out0_valid; k++) cycle();
      check_eq("bp_started", 64'(bus.aso_out0_valid), 64'd1);
      bus.aso_out0_ready = 1'b0;
      snap = {bus.aso_out0_data, bus.aso_out0_startofpacket, bus.aso_out0_endofpacket,
              bus.aso_out0_channel};
      for (int k = 0; k < 5; k++) begin
         cycle();
         #1;
         check_eq("bp_stable", {bus.aso_out0_valid, bus.aso_out0_data, bus.aso_out0_startofpacket,
                                bus.aso_out0_endofpacket, bus.aso_out0_channel}, {1'b1, snap});
         check_eq("bp_in_ready", 64'(bus.asi_in_ready), 64'd0);
      end
      bus.aso_out0_ready = 1'b1;
      drain(50);

      // Mask and orphan
      mask = 4'b1101;
      push_pkt(1, 2);
      push_orphan(2);
      drive();
      repeat (4) cycle();
      check_eq("mask_in1_held", 64'(src_q[1].size()), 64'd2);
      check_eq("orphan_taken", 64'(src_q[2].size()), 64'd0);
      check_eq("mask_idle", 64'(busy), 64'd0);
      check_eq("drop_set", 64'(drop_flag), 64'd1);
      check_eq("drop_model", 64'(drop_flag), 64'(model_drop));
      stat_clear = 1'b1;
      cycle();
      stat_clear = 1'b0;
      check_eq("drop_cleared", 64'(drop_flag), 64'd0);
      check_eq("count_cleared", 64'(pkt_count), 64'd0);
      mask = '1;
      drain(50);
      check_eq("unmask_in1", 64'(start_log[start_log.size()-1]), 64'd1);

      // Single-beat packet on in3, then an in0 packet
      do_reset();
      push_pkt(3, 1);
      drive();
      cycle();
      busy_seq[2] = busy;
      push_pkt(0, 3);
      drive();
      cycle();
      busy_seq[1] = busy;
      cycle();
      busy_seq[0] = busy;
      check_eq("sb_busy_seq", 64'(busy_seq), 64'b101);
      drain(50);
      check_eq("sb_count", 64'(pkt_count), 64'd2);
      check_eq("sb_count_model", 64'(pkt_count), 64'(model_cnt));

      // Reset mid-packet, then a fresh packet
      push_pkt(0, 4);
      drive();
      repeat (3) cycle();
      rst = 1'b1;
      flush();
      drive();
      cycle();
      rst = 1'b0;
      check_eq("mid_rst_valid", 64'(bus.aso_out0_valid), 64'd0);
      check_eq("mid_rst_count", 64'(pkt_count), 64'd0);
      check_eq("mid_rst_busy", 64'(busy), 64'd0);
      push_pkt(0, 3);
      drive();
      drain(50);
      check_eq("post_rst_count", 64'(pkt_count), 64'd1);

      // Randomized traffic
      do_reset();
      rand_mode = 1'b1;
      repeat (3000) cycle();
      rand_mode          = 1'b0;
      stat_clear         = 1'b0;
      gap                = '0;
      bus.aso_out0_ready = 1'b1;
      drive();
      drain(600);
      check_eq("rand_count", 64'(pkt_count), 64'(model_cnt));
      check_eq("rand_drop", 64'(drop_flag), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/packet_stream_rr_arbiter.md
Name: packet_stream_rr_arbiter

Overview:
Round-robin, packet-locked arbiter that merges NUM_INPUTS wide Avalon-ST packet sources onto one wide Avalon-ST sink. It sits in front of the packet symbol-width TX adapter so that several producers can share that adapter. Once a source is granted, it keeps the grant until its endofpacket beat is accepted. A registered output stage carries channel ID and status.

Parameters:
NUM_INPUTS, 4, number of requesting sources (2..16)
DATA_WIDTH, 256, beat width in bits, equal to the downstream adapter input width
CH_WIDTH, $clog2(NUM_INPUTS) (min 1), channel ID width

Ports:
clock_clk  in  1  single clock
reset_reset  in  1  synchronous, active-high reset
asi_in_data  in  NUM_INPUTS*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
asi_in_valid  in  NUM_INPUTS  per-source valid
asi_in_startofpacket  in  NUM_INPUTS  per-source SOP
asi_in_endofpacket  in  NUM_INPUTS  per-source EOP
asi_in_ready  out  NUM_INPUTS  per-source ready (combinational)
aso_out0_data  out  DATA_WIDTH  registered output beat
aso_out0_valid  out  1  output valid
aso_out0_ready  in  1  downstream ready
aso_out0_startofpacket  out  1  output SOP
aso_out0_endofpacket  out  1  output EOP
aso_out0_channel  out  CH_WIDTH  source index of current beat
cfg_enable_mask  in  NUM_INPUTS  1 = source may win arbitration
stat_clear  in  1  one-cycle pulse that clears status
stat_drop_flag  out  1  sticky: an orphan beat was discarded
stat_pkt_count  out  16  packets forwarded (EOP accepted downstream), wraps at 0xFFFF->0
stat_busy  out  1  high while in STREAM

Behaviour:
- Reset (sync, on clock edge):
  - State goes to IDLE.
  - last_grant = NUM_INPUTS-1, so input 0 has first priority.
  - aso_out0_valid/sop/eop = 0; data = 0; channel = 0.
  - stat_drop_flag = 0; stat_pkt_count = 0; stat_busy = 0.
  - Reset mid-packet discards the partial packet. No EOP is generated.
- Output stage is a single register. It loads when (!aso_out0_valid || aso_out0_ready). It holds data/sop/eop/channel stable while valid && !ready.
- can_load = !aso_out0_valid || aso_out0_ready.
- State IDLE:
  - Request vector req[i] = asi_in_valid[i] & asi_in_startofpacket[i] & cfg_enable_mask[i].
  - If any req is set, grant the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_INPUTS.
  - Record it in grant and last_grant, then go to STREAM.
  - Arbitration consumes one cycle: all asi_in_ready are 0 in the decision cycle, and no beat is accepted.
  - Orphan beats: for each i with valid & !startofpacket in IDLE, assert asi_in_ready[i], discard the beat, and set stat_drop_flag. Sources valid with SOP but masked are held (ready 0).
- State STREAM:
  - asi_in_ready[grant] = can_load; every other ready is 0.
  - Accepted beat: load the output register with data, sop, eop, and channel = grant.
  - Accepting an EOP beat returns the block to IDLE next cycle. Re-arbitration happens in that IDLE cycle, which gives a guaranteed one-cycle bubble between packets on the input side.
  - SOP arriving on the granted input mid-packet is forwarded as-is. The block does not repair framing.
  - A change to cfg_enable_mask during STREAM does not abort the current packet. It affects only the next arbitration.
- Latency: a SOP beat presented in idle with output free appears on aso_out0 two cycles later (arbitrate, accept). Subsequent beats appear 1 cycle after acceptance, giving full throughput when downstream ready=1.
- stat_pkt_count increments when aso_out0_valid & ready & endofpacket.
- stat_clear zeroes stat_pkt_count and stat_drop_flag. If clear and set/increment occur in the same cycle, clear wins.
- Fairness: after input k completes a packet, every other requesting enabled input is served before k again.
- stat_busy = (state == STREAM).

Test Plan:
- Single source: in0 sends a 3-beat packet (A, B, C) with out ready=1 → aso_out0 shows A(sop, ch0) at cycle T+2, B at T+3, C(eop) at T+4; stat_pkt_count = 1.
- Round robin: in0..in3 all hold 2-beat packets continuously → grant order 0, 1, 2, 3, 0, each packet uninterrupted, one input-side bubble between packets; channel field matches.
- Backpressure: aso_out0_ready low for 5 cycles mid-packet → output data/sop/eop/channel stable, granted asi_in_ready = 0, no beat lost or duplicated.
- Mask and orphan: cfg_enable_mask = 4'b1101, in1 valid with SOP, in2 non-SOP beat in IDLE → in1 never granted, in2 beat dropped, stat_drop_flag = 1; a stat_clear pulse → 0.
- Single-beat packet (sop & eop same beat) on in3, followed immediately by an in0 packet → both forwarded, stat_pkt_count = 2, grant returns to IDLE for exactly one cycle.
- Reset asserted mid-packet → next cycle aso_out0_valid = 0, all counters 0; a next fresh packet from in0 forwards correctly.
